fcsr_ctrl: RTL

FCSR_CTRL -- requirements
Module: fcsr_ctrl

---
 rtl/fcsr_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fcsr_ctrl.sv
// rtl/fcsr_ctrl.sv - floating-point CSR controller (fflags/frm/fcsr) with flag accrual; optional FCSR_RM_CHECK_EN adds rm_illegal
module fcsr_ctrl #(
  parameter logic [2:0] FRM_RESET = 3'b000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        csr_valid,
  output logic        csr_ready,
  input  logic [11:0] csr_addr,
  input  logic [1:0]  csr_op,
  input  logic [31:0] csr_wdata,
  output logic        csr_rvalid,
  input  logic        csr_rready,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        fpu_flag_valid,
  input  logic [4:0]  fpu_flags,
  input  logic [2:0]  inst_rm,
  output logic [2:0]  frm_out,
  output logic [4:0]  fflags_out,
  output logic [2:0]  rm_eff
`ifdef FCSR_RM_CHECK_EN
  ,
  output logic        rm_illegal
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [11:0] ADDR_FFLAGS = 12'h001;
  localparam logic [11:0] ADDR_FRM    = 12'h002;
  localparam logic [11:0] ADDR_FCSR   = 12'h003;

  state_t      state, state_nxt;
  logic [11:0] addr_q;
  logic [1:0]  op_q;
  logic [7:0]  wdata_q;
  logic [4:0]  flag_in;
  logic [4:0]  flags_acc;
  logic        sel_ff, sel_frm, sel_fcsr, addr_ok;
  logic [7:0]  old_val;
  logic [7:0]  new_val;
  logic        do_write;
  logic        unused_wdata_hi;

  // Only the low byte of the operand can ever reach a field.
  assign unused_wdata_hi = ^csr_wdata[31:8];

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and handshake: accept only in IDLE, one EXEC cycle, hold RESP until consumed.
  always_comb begin
    state_nxt = state;
    csr_ready = 1'b0;
    case (state)
      IDLE: begin
        csr_ready = 1'b1;
        if (csr_valid) state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (csr_rready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request operands at acceptance.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= 12'h000;
      op_q    <= 2'b00;
      wdata_q <= 8'h00;
    end else if (state == IDLE && csr_valid) begin
      addr_q  <= csr_addr;
      op_q    <= csr_op;
      wdata_q <= csr_wdata[7:0];
    end
  end

  // Flags arriving this cycle are folded in before any CSR read or write sees them.
  always_comb begin
    flag_in   = fpu_flag_valid ? fpu_flags : 5'b00000;
    flags_acc = fflags_out | flag_in;
    sel_ff    = (addr_q == ADDR_FFLAGS);
    sel_frm   = (addr_q == ADDR_FRM);
    sel_fcsr  = (addr_q == ADDR_FCSR);
    addr_ok   = sel_ff | sel_frm | sel_fcsr;
    old_val   = 8'h00;
    if (sel_ff)   old_val = {3'b000, flags_acc};
    if (sel_frm)  old_val = {5'b00000, frm_out};
    if (sel_fcsr) old_val = {frm_out, flags_acc};
    new_val  = old_val;
    do_write = 1'b0;
    case (op_q)
      2'b01: begin new_val = wdata_q;            do_write = addr_ok; end
      2'b10: begin new_val = old_val | wdata_q;  do_write = addr_ok; end
      2'b11: begin new_val = old_val & ~wdata_q; do_write = addr_ok; end
      default: begin new_val = old_val;          do_write = 1'b0;    end
    endcase
  end

  // Architectural state and response registers; EXEC writes after accrual, RESP holds until rready.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fflags_out  <= 5'b00000;
      frm_out     <= FRM_RESET;
      csr_rvalid  <= 1'b0;
      csr_rdata   <= 32'h0;
      csr_illegal <= 1'b0;
    end else begin
      fflags_out <= flags_acc;
      if (state == EXEC) begin
        csr_rvalid  <= 1'b1;
        csr_rdata   <= {24'h0, old_val};
        csr_illegal <= ~addr_ok;
        if (do_write) begin
          if (sel_ff)   fflags_out <= new_val[4:0];
          if (sel_frm)  frm_out    <= new_val[2:0];
          if (sel_fcsr) begin
            frm_out    <= new_val[7:5];
            fflags_out <= new_val[4:0];
          end
        end
      end else if (state == RESP && csr_rready) begin
        csr_rvalid <= 1'b0;
      end
    end
  end

  // Dynamic rounding mode (3'b111) defers to the registered frm.
  always_comb begin
    rm_eff = (inst_rm == 3'b111) ? frm_out : inst_rm;
  end

`ifdef FCSR_RM_CHECK_EN
  // Reserved encodings, including a dynamic mode that resolves to 3'b111.
  always_comb begin
    rm_illegal = (rm_eff == 3'b101) || (rm_eff == 3'b110) || (rm_eff == 3'b111);
  end
`endif

endmodule
